dma_priority_resolver: RTL and testbench
========================================

// Module: dma_priority_resolver
// PURPOSE
//  Arbitration stage of the 8237A-style DMA, downstream of the DMA register interface (PR view).
//  Consumes commandReg/requestReg/maskReg plus the DREQ pins and picks one channel.
//  Runs the HRQ/HLDA bus handshake with the CPU, drives DACK, and tells timing control
//  which channel owns the bus.
// PARAMETERS
//  NUM_CH  4  number of DMA channels; the design is verified only at 4
//  CH_W    2  channel index width, $clog2(NUM_CH)
// PORTS
//  CLK         in   1       system clock; all state on rising edge
//  RESET       in   1       asynchronous, active-high reset
//  DREQ        in   NUM_CH  raw channel request pins; polarity set by commandReg[6]
//  HLDA        in   1       hold acknowledge from CPU
//  commandReg  in   8       [2]=controller disable, [4]=rotating priority,
//                           [6]=DREQ active-low, [7]=DACK active-high
//  requestReg  in   8       [NUM_CH-1:0] software requests; not maskable
//  maskReg     in   8       [NUM_CH-1:0] per-channel DREQ mask, 1=masked
//  srvDone     in   1       one-cycle pulse from timing control: transfer/service finished
//  HRQ         out  1       hold request to CPU
//  DACK        out  NUM_CH  channel acknowledge, polarity set by commandReg[7]
//  activeCh    out  CH_W    granted channel index
//  chValid     out  1       1 while in GRANT (activeCh valid)
//  reqPending  out  NUM_CH  unmasked request status, feeds statusReg[7:4]
// BEHAVIOUR
//  - Reset values: state IDLE, HRQ=0, chValid=0, activeCh=0, lowest-priority pointer=NUM_CH-1.
//    DACK is driven at its inactive level: 4'hF while commandReg=0.
//  - Request vector: dreq = DREQ ^ {NUM_CH{commandReg[6]}} (after the optional sync).
//    eff = (dreq & ~maskReg) | requestReg. reqPending = dreq | requestReg, registered.
//  - Fixed priority (cmd[4]=0): ch0 is highest, ch3 lowest.
//  - Rotating priority (cmd[4]=1): search starts at lowPtr+1 mod NUM_CH.
//    lowPtr <= activeCh only on srvDone, so the serviced channel becomes lowest.
//  - FSM, 4 states:
//    IDLE:    cmd[2]=0 && eff!=0 -> REQ; winner latched into activeCh, HRQ=1 the next cycle.
//    REQ:     winner re-arbitrated every cycle.
//             HLDA=1 -> GRANT; winner frozen; DACK[activeCh] active and chValid=1 the next cycle.
//             eff==0 or cmd[2]=1 -> IDLE, HRQ=0.
//    GRANT:   srvDone -> RELEASE; HRQ=0, DACK inactive, chValid=0 the next cycle.
//             HLDA drops without srvDone -> IDLE (abort); lowPtr unchanged.
//             cmd[2] set during GRANT is ignored until srvDone.
//    RELEASE: wait for HLDA=0, then IDLE. HRQ is never re-raised while HLDA=1.
//  - Latency (sync off): DREQ edge -> HRQ = 1 cycle; HLDA rise -> DACK = 1 cycle;
//    srvDone -> HRQ low = 1 cycle.
//  - Simultaneous events:
//    srvDone together with new requests: release takes effect first; new arbitration only after RELEASE->IDLE.
//    srvDone together with HLDA fall: -> RELEASE, which exits to IDLE next cycle.
//  - DACK is combinational from the registered state and commandReg[7].
//    A polarity change mid-grant takes effect immediately.
//  - Memory-to-memory (cmd[0]) is handled by timing control and is not decoded here.
// CONFIGURATION
//  DMA_DREQ_SYNC_EN defined:
//    - DREQ passes through a 2-flop synchronizer, reset to 0, before polarity correction.
//    - DREQ -> HRQ latency becomes 3 cycles.
//    - reqPending lags the pin by 2 extra cycles.
//  DMA_DREQ_SYNC_EN undefined:
//    - DREQ is used directly; the source must already be CLK-synchronous.
// TESTING
//  T1 Fixed priority:
//     cmd=00, mask=0, DREQ=4'b1010, HLDA raised 2 cycles after HRQ
//     -> HRQ=1, activeCh=1, DACK=4'b1101, chValid=1.
//  T2 Rotating priority:
//     cmd=8'h10, DREQ=4'b1111 held; srvDone after each grant
//     -> grant order 0,1,2,3,0; HRQ low and then HLDA low between grants.
//  T3 Mask and software request:
//     mask=4'hF, DREQ=4'hF -> HRQ stays 0, reqPending=4'hF.
//     Then requestReg=8'h04 -> activeCh=2.
//  T4 Polarity:
//     cmd=8'hC0, DREQ=4'b1110 (ch0 active-low request)
//     -> activeCh=0, DACK=4'b0001.
//  T5 Abort and disable:
//     HLDA dropped in GRANT without srvDone -> IDLE, lowPtr unchanged.
//     cmd[2]=1 in REQ -> HRQ=0 the next cycle.
//  T6 Reset mid-GRANT:
//     RESET asserted asynchronously while DACK is active
//     -> HRQ=0, chValid=0, DACK=4'hF immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dma_priority_resolver.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver
//
// Arbitration stage of an 8237A-style DMA controller. It combines the DREQ pins
// with the software request and mask registers, picks one channel (fixed or
// rotating priority), runs the HRQ/HLDA hold handshake with the CPU, drives
// DACK and reports which channel owns the bus to timing control.
//
// Optional build macro:
//   DMA_DREQ_SYNC_EN  - route DREQ through a 2-flop synchronizer (reset to 0)
//                       before polarity correction. DREQ->HRQ latency becomes
//                       3 cycles and reqPending lags the pins by 2 more cycles.
//                       Undefined: DREQ must already be CLK-synchronous.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-high reset
//   DREQ        in   [NUM_CH] raw request pins, polarity from commandReg[6]
//   HLDA        in   hold acknowledge from the CPU
//   commandReg  in   [8] [2]=disable [4]=rotating [6]=DREQ low [7]=DACK high
//   requestReg  in   [8] software requests (not maskable)
//   maskReg     in   [8] per-channel DREQ mask, 1 = masked
//   srvDone     in   one-cycle pulse, service of the granted channel finished
//   HRQ         out  hold request to the CPU
//   DACK        out  [NUM_CH] channel acknowledge, polarity from commandReg[7]
//   activeCh    out  [CH_W] granted channel index
//   chValid     out  high while the grant is held
//   reqPending  out  [NUM_CH] registered unmasked request status
//   dbg_state   out  [2] FSM state: 0 IDLE, 1 REQ, 2 GRANT, 3 RELEASE
//
// Handshake: HRQ rises once a request is seen with the controller enabled and
// HLDA low. The grant starts on the first cycle HLDA is seen high while HRQ is
// up and ends on srvDone (normal) or an HLDA fall (abort). After srvDone HRQ
// stays low until HLDA has been observed low, so HRQ is never re-raised while
// the CPU is still holding the bus.
// -----------------------------------------------------------------------------
module dma_priority_resolver #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic              srvDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   activeCh,
    output logic              chValid,
    output logic [NUM_CH-1:0] reqPending,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                hrq_q, hrq_d;
    logic                ch_valid_q, ch_valid_d;
    logic [CH_W-1:0]     active_ch_q, active_ch_d;
    logic [CH_W-1:0]     low_ptr_q, low_ptr_d;
    logic [NUM_CH-1:0]   req_pending_q, req_pending_d;

    logic [NUM_CH-1:0]   dreq_raw;
    logic [NUM_CH-1:0]   dreq;
    logic [NUM_CH-1:0]   eff;
    logic [NUM_CH-1:0]   grant_vec;
    logic [CH_W-1:0]     search_start;
    logic [CH_W-1:0]     search_idx;
    logic [CH_W-1:0]     winner;
    logic                winner_found;
    logic                ctrl_disable;
    logic                unused_bits;

    // Command bits not decoded here (mem-to-mem etc. belong to timing control).
    assign unused_bits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                           requestReg[7:NUM_CH], maskReg[7:NUM_CH]};

`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = DREQ;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign dreq_raw = sync2_q;
`else
    assign dreq_raw = DREQ;
`endif

    assign ctrl_disable = commandReg[2];
    assign dreq         = dreq_raw ^ {NUM_CH{commandReg[6]}};
    assign eff          = (dreq & ~maskReg[NUM_CH-1:0]) | requestReg[NUM_CH-1:0];

    // Priority search: fixed starts at ch0; rotating starts just above the
    // channel serviced last, so that channel ends up lowest.
    always_comb begin
        search_start = commandReg[4] ? low_ptr_q + CH_W'(1) : '0;
        search_idx   = '0;
        winner       = '0;
        winner_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            search_idx = search_start + CH_W'(i);
            if (!winner_found && eff[search_idx]) begin
                winner_found = 1'b1;
                winner       = search_idx;
            end
        end
    end

    // Next-state / output logic
    always_comb begin
        state_d       = state_q;
        hrq_d         = hrq_q;
        ch_valid_d    = ch_valid_q;
        active_ch_d   = active_ch_q;
        low_ptr_d     = low_ptr_q;
        req_pending_d = dreq | requestReg[NUM_CH-1:0];

        case (state_q)
            S_IDLE: begin
                if (!ctrl_disable && winner_found && !HLDA) begin
                    state_d     = S_REQ;
                    hrq_d       = 1'b1;
                    active_ch_d = winner;
                end
            end
            S_REQ: begin
                if (ctrl_disable || !winner_found) begin
                    state_d = S_IDLE;
                    hrq_d   = 1'b0;
                end else begin
                    // Keep following the best request until the CPU yields.
                    active_ch_d = winner;
                    if (HLDA) begin
                        state_d    = S_GRANT;
                        ch_valid_d = 1'b1;
                    end
                end
            end
            S_GRANT: begin
                // The disable bit is deliberately not looked at here: an
                // in-flight service always runs to srvDone or HLDA loss.
                if (srvDone) begin
                    state_d    = S_RELEASE;
                    hrq_d      = 1'b0;
                    ch_valid_d = 1'b0;
                    low_ptr_d  = active_ch_q;
                end else if (!HLDA) begin
                    // Abort: the serviced channel keeps its priority slot.
                    state_d    = S_IDLE;
                    hrq_d      = 1'b0;
                    ch_valid_d = 1'b0;
                end
            end
            S_RELEASE: begin
                if (!HLDA) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                hrq_d      = 1'b0;
                ch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            hrq_q         <= 1'b0;
            ch_valid_q    <= 1'b0;
            active_ch_q   <= '0;
            low_ptr_q     <= CH_W'(NUM_CH - 1);
            req_pending_q <= '0;
        end else begin
            state_q       <= state_d;
            hrq_q         <= hrq_d;
            ch_valid_q    <= ch_valid_d;
            active_ch_q   <= active_ch_d;
            low_ptr_q     <= low_ptr_d;
            req_pending_q <= req_pending_d;
        end
    end

    // DACK is decoded from registered state so that reset and polarity
    // changes show up on the pins without waiting for a clock edge.
    always_comb begin
        grant_vec = '0;
        if (state_q == S_GRANT) begin
            grant_vec[active_ch_q] = 1'b1;
        end
        DACK = commandReg[7] ? grant_vec : ~grant_vec;
    end

    assign HRQ        = hrq_q;
    assign chValid    = ch_valid_q;
    assign activeCh   = active_ch_q;
    assign reqPending = req_pending_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = '0;
  logic       HLDA = 1'b0;
  logic [7:0] commandReg = '0;
  logic [7:0] requestReg = '0;
  logic [7:0] maskReg = '0;
  logic       srvDone = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       chValid;
  logic [3:0] reqPending;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  dma_priority_resolver #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA),
    .commandReg(commandReg), .requestReg(requestReg), .maskReg(maskReg),
    .srvDone(srvDone), .HRQ(HRQ), .DACK(DACK), .activeCh(activeCh),
    .chValid(chValid), .reqPending(reqPending), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 idle, 1 requesting, 2 granted, 3 releasing.
  // Priority is computed as a rank per channel (distance above the lowest slot).
  // ---------------------------------------------------------------------------
  int         m_phase = 0;
  int         m_ch = 0;
  int         m_low = 3;
  logic [3:0] m_rp = '0;
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;

  function automatic int pick(input logic [3:0] e, input bit rot, input int low);
    int best = -1;
    int best_rank = 99;
    for (int c = 0; c < 4; c++) begin
      if (e[c]) begin
        int rank;
        rank = rot ? (c - low - 1 + 8) % 4 : c;
        if (rank < best_rank) begin
          best_rank = rank;
          best = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] exp_dack(input int phase, input int ch, input bit high);
    logic [3:0] oh;
    oh = (phase == 2) ? (4'b0001 << ch) : 4'b0000;
    return high ? oh : ~oh;
  endfunction

  // compare process: step the model on each rising edge, check #1 later
  always @(posedge CLK) begin
    logic [3:0] pin_seen;
    logic [3:0] dr;
    logic [3:0] e;
    int w;
    if (RESET) begin
      m_phase = 0; m_ch = 0; m_low = 3; m_rp = '0; m_s1 = '0; m_s2 = '0;
    end else begin
`ifdef DMA_DREQ_SYNC_EN
      pin_seen = m_s2;
      m_s2 = m_s1;
      m_s1 = DREQ;
`else
      pin_seen = DREQ;
`endif
      dr = pin_seen ^ {4{commandReg[6]}};
      e  = (dr & ~maskReg[3:0]) | requestReg[3:0];
      w  = pick(e, commandReg[4], m_low);
      case (m_phase)
        0: if (!commandReg[2] && e != 0 && !HLDA) begin m_phase = 1; m_ch = w; end
        1: if (commandReg[2] || e == 0) m_phase = 0;
           else begin m_ch = w; if (HLDA) m_phase = 2; end
        2: if (srvDone) begin m_low = m_ch; m_phase = 3; end
           else if (!HLDA) m_phase = 0;
        default: if (!HLDA) m_phase = 0;
      endcase
      m_rp = dr | requestReg[3:0];
    end
    #1;
    check("model_hrq", {7'b0, HRQ}, {7'b0, (m_phase == 1 || m_phase == 2)});
    check("model_chvalid", {7'b0, chValid}, {7'b0, (m_phase == 2)});
    check("model_activech", {6'b0, activeCh}, 8'(m_ch));
    check("model_dack", {4'b0, DACK}, {4'b0, exp_dack(m_phase, m_ch, commandReg[7])});
    check("model_reqpending", {4'b0, reqPending}, {4'b0, m_rp});
    check("model_state", {6'b0, dbg_state}, 8'(m_phase));
  end

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; HLDA = 1'b0; srvDone = 1'b0; DREQ = '0;
    commandReg = '0; requestReg = '0; maskReg = '0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_hrq(input string tag);
    int n = 0;
    while (HRQ !== 1'b1 && n < 12) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (HRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_hrq_timeout: got HRQ=%b required 1 within 12 cycles", tag, HRQ);
    end
  endtask

  task automatic finish_service();
    srvDone = 1'b1;
    cyc(1);
    srvDone = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // directed tests
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] rot_order [5];
    rot_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    cyc(2);
    // reset values while RESET is held
    check("rst_hrq", {7'b0, HRQ}, 8'h00);
    check("rst_chvalid", {7'b0, chValid}, 8'h00);
    check("rst_activech", {6'b0, activeCh}, 8'h00);
    check("rst_dack", {4'b0, DACK}, 8'h0F);
    check("rst_reqpending", {4'b0, reqPending}, 8'h00);
    RESET = 1'b0;
    cyc(1);

    // T1 fixed priority
    DREQ = 4'b1010;
    wait_hrq("t1");
    cyc(2);
    HLDA = 1'b1;
    cyc(2);
    check("t1_hrq", {7'b0, HRQ}, 8'h01);
    check("t1_activech", {6'b0, activeCh}, 8'h01);
    check("t1_dack", {4'b0, DACK}, 8'h0D);
    check("t1_chvalid", {7'b0, chValid}, 8'h01);
    finish_service();
    check("t1_release_hrq", {7'b0, HRQ}, 8'h00);
    check("t1_release_dack", {4'b0, DACK}, 8'h0F);
    DREQ = '0; HLDA = 1'b0;
    cyc(2);

    // T2 rotating priority
    do_reset();
    commandReg = 8'h10; DREQ = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_hrq("t2");
      HLDA = 1'b1;
      cyc(2);
      check("t2_grant_order", {6'b0, activeCh}, {6'b0, rot_order[k]});
      check("t2_chvalid", {7'b0, chValid}, 8'h01);
      finish_service();
      check("t2_hrq_low_in_release", {7'b0, HRQ}, 8'h00);
      cyc(1);
      check("t2_hrq_held_low_while_hlda", {7'b0, HRQ}, 8'h00);
      HLDA = 1'b0;
      cyc(1);
    end
    DREQ = '0;
    cyc(3);

    // T3 mask and software request
    do_reset();
    maskReg = 8'h0F; DREQ = 4'hF;
    cyc(4);
    check("t3_masked_hrq", {7'b0, HRQ}, 8'h00);
    check("t3_reqpending", {4'b0, reqPending}, 8'h0F);
    requestReg = 8'h04;
    wait_hrq("t3");
    HLDA = 1'b1;
    cyc(2);
    check("t3_sw_activech", {6'b0, activeCh}, 8'h02);
    finish_service();
    HLDA = 1'b0; requestReg = '0; maskReg = '0; DREQ = '0;
    cyc(2);

    // T4 polarity
    do_reset();
    commandReg = 8'hC0; DREQ = 4'b1110;
    wait_hrq("t4");
    HLDA = 1'b1;
    cyc(2);
    check("t4_activech", {6'b0, activeCh}, 8'h00);
    check("t4_dack_high", {4'b0, DACK}, 8'h01);
    commandReg = 8'h40;
    #1;
    check("t4_dack_flip_low", {4'b0, DACK}, 8'h0E);
    cyc(1);
    finish_service();
    HLDA = 1'b0; commandReg = '0; DREQ = '0;
    cyc(2);

    // T5 abort keeps the rotation pointer
    do_reset();
    commandReg = 8'h10; DREQ = 4'b0001;
    wait_hrq("t5a");
    HLDA = 1'b1;
    cyc(2);
    check("t5_grant_ch0", {6'b0, activeCh}, 8'h00);
    HLDA = 1'b0; DREQ = '0;
    cyc(1);
    check("t5_abort_chvalid", {7'b0, chValid}, 8'h00);
    check("t5_abort_hrq", {7'b0, HRQ}, 8'h00);
    cyc(3);
    DREQ = 4'hF;
    wait_hrq("t5b");
    HLDA = 1'b1;
    cyc(2);
    check("t5_lowptr_unchanged", {6'b0, activeCh}, 8'h00);
    finish_service();
    HLDA = 1'b0; DREQ = '0;
    cyc(2);

    // disable while requesting
    commandReg = 8'h00; DREQ = 4'b0010;
    wait_hrq("t5c");
    commandReg = 8'h04;
    cyc(1);
    check("t5_disable_hrq", {7'b0, HRQ}, 8'h00);
    commandReg = 8'h00; DREQ = '0;
    cyc(2);

    // disable during grant is ignored until srvDone
    DREQ = 4'b0010;
    wait_hrq("t5d");
    HLDA = 1'b1;
    cyc(1);
    commandReg = 8'h04;
    cyc(2);
    check("t5_disable_in_grant", {7'b0, chValid}, 8'h01);
    // srvDone together with HLDA fall, new request waiting
    commandReg = 8'h00; DREQ = 4'b1000;
    srvDone = 1'b1; HLDA = 1'b0;
    cyc(1);
    srvDone = 1'b0;
    check("t5_srv_hlda_release_hrq", {7'b0, HRQ}, 8'h00);
    cyc(1);
    check("t5_no_rearb_before_idle", {7'b0, HRQ}, 8'h00);
    wait_hrq("t5e");
    DREQ = '0;
    cyc(3);

    // T6 asynchronous reset mid-grant
    do_reset();
    DREQ = 4'b0001;
    wait_hrq("t6");
    HLDA = 1'b1;
    cyc(2);
    check("t6_dack_before_reset", {4'b0, DACK}, 8'h0E);
    #2;
    RESET = 1'b1;
    #1;
    check("t6_async_hrq", {7'b0, HRQ}, 8'h00);
    check("t6_async_chvalid", {7'b0, chValid}, 8'h00);
    check("t6_async_dack", {4'b0, DACK}, 8'h0F);
    @(negedge CLK);
    HLDA = 1'b0; DREQ = '0;
    RESET = 1'b0;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
